// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU, unified memory and register file,
// with a watchdog that abandons memory waits that exceed MEM_WAIT_MAX cycles.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int unsigned CntW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CntW-1:0] WaitMax = CntW'(MEM_WAIT_MAX);
    localparam logic WdogOn = (MEM_WAIT_MAX != 0);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StBranch   = 4'd9;
    localparam logic [3:0] StJal      = 4'd10;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluXor = 4'b0100;
    localparam logic [3:0] AluSlt = 4'b0101;
    localparam logic [3:0] AluSll = 4'b0110;
    localparam logic [3:0] AluSrl = 4'b0111;
    localparam logic [3:0] AluSra = 4'b1000;

    logic [3:0]      r_state;
    logic [3:0]      w_state_next;
    logic [CntW-1:0] r_wait_cnt;
    logic [CntW-1:0] w_wait_cnt_next;
    logic            w_wait_state;
    logic            w_timeout;
    logic            w_branch_ok;
    logic [3:0]      w_alu_func;

    assign w_wait_state = (r_state == StFetch) || (r_state == StMemRead) ||
                          (r_state == StMemWrite);
    // A ready memory in the expiry cycle completes normally instead of timing out.
    assign w_timeout    = WdogOn && w_wait_state && !mem_ready && (r_wait_cnt == WaitMax);
    assign w_branch_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);

    always_comb begin
        w_alu_func = AluAdd;
        unique case (funct3)
            3'b000:  w_alu_func = (funct7_5 && (r_state == StExecR)) ? AluSub : AluAdd;
            3'b001:  w_alu_func = AluSll;
            3'b010:  w_alu_func = AluSlt;
            3'b100:  w_alu_func = AluXor;
            3'b101:  w_alu_func = funct7_5 ? AluSra : AluSrl;
            3'b110:  w_alu_func = AluOr;
            3'b111:  w_alu_func = AluAnd;
            default: w_alu_func = AluAdd;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFetch:    if (mem_ready) w_state_next = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: w_state_next = StMemAdr;
                    OpReg:           w_state_next = StExecR;
                    OpImm:           w_state_next = StExecI;
                    OpBranch:        w_state_next = w_branch_ok ? StBranch : StFetch;
                    OpJal:           w_state_next = StJal;
                    default:         w_state_next = StFetch;
                endcase
            end
            StMemAdr:   w_state_next = (op == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) w_state_next = StMemWb;
            StMemWb:    w_state_next = StFetch;
            StMemWrite: if (mem_ready) w_state_next = StFetch;
            StExecR:    w_state_next = StAluWb;
            StExecI:    w_state_next = StAluWb;
            StAluWb:    w_state_next = StFetch;
            StBranch:   w_state_next = StFetch;
            StJal:      w_state_next = StAluWb;
            default:    w_state_next = StFetch;
        endcase
        if (w_timeout) w_state_next = StFetch;
    end

    // Only a wait that keeps the FSM in place advances the counter; any exit clears it.
    assign w_wait_cnt_next = (w_wait_state && !mem_ready && !w_timeout) ?
                             r_wait_cnt + CntW'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StFetch;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = AluAdd;
        ImmSrc      = 2'b00;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = w_timeout;
        case (r_state)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (op)
                    OpLoad, OpStore, OpReg, OpImm, OpJal: illegal_op = 1'b0;
                    OpBranch: illegal_op = !w_branch_ok;
                    default:  illegal_op = 1'b1;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OpStore) ? 2'b01 : 2'b00;
            end
            StMemRead:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                AdrSrc     = 1'b1;
                MemWrite   = !w_timeout;
                instr_done = mem_ready;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_alu_func;
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_func;
            end
            StAluWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                ALUSrcA    = 2'b10;
                ALUControl = AluSub;
                PCWrite    = funct3[0] ? !zero : zero;
                instr_done = 1'b1;
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 2'b11;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            PCWrite     = 1'b0;
            AdrSrc      = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            ResultSrc   = 2'b00;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ALUControl  = AluAdd;
            ImmSrc      = 2'b00;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions plus a random instruction stream, each
// expanded by an instruction-level model into the expected per-cycle control word.
module tb_multicycle_ctrl;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4;
    localparam logic [3:0] SLT = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op, mem_timeout;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mr;
        logic        z;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [19:0] v;
        string       tag;
    } cyc_t;
    cyc_t q[$];

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                  ImmSrc, RegWrite, instr_done, illegal_op, mem_timeout};

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    function automatic logic [19:0] o(input logic pc, adr, mw, irw, input logic [1:0] rs, sa,
                                      sb, input logic [3:0] alu, input logic [1:0] imm,
                                      input logic rw, dn, il, to);
        return {pc, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, il, to};
    endfunction

    function automatic void push(input logic mr, input logic z, input logic [19:0] v,
                                 input string tag);
        cyc_t c;
        c.mr = mr; c.z = z; c.v = v; c.tag = tag;
        c.opc = cur_op; c.f3 = cur_f3; c.f7 = cur_f7;
        q.push_back(c);
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? SUB : ADD;
            3'd1:    return SLL;
            3'd2:    return SLT;
            3'd4:    return XOR;
            3'd5:    return f7 ? SRA : SRL;
            3'd6:    return OR;
            3'd7:    return AND;
            default: return ADD;
        endcase
    endfunction

    function automatic void fetch_cycles(input int fw);
        for (int i = 0; i < fw; i++)
            push(1'b0, rb(), o(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD, 2'b00, 0, 0, 0, 0), "fetch_wait");
        push(1'b1, rb(), o(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, ADD, 2'b00, 0, 0, 0, 0), "fetch");
    endfunction

    function automatic void decode_cycle(input logic ill);
        push(rb(), rb(), o(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, 2'b10, 0, 0, ill, 0), "decode");
    endfunction

    // Expected cycle-by-cycle control words for one instruction, given memory wait counts.
    function automatic void plan(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fw, input int mw);
        logic legal;
        logic [19:0] wb;
        cur_op = opc; cur_f3 = f3; cur_f7 = f7;
        legal = (opc == LW) || (opc == SW) || (opc == RT) || (opc == IT) || (opc == JL) ||
                ((opc == BR) && (f3 == 3'd0 || f3 == 3'd1));
        wb = o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 1, 1, 0, 0);
        fetch_cycles(fw);
        decode_cycle(!legal);
        if (!legal) return;
        case (opc)
            LW: begin
                push(rb(), rb(), o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 2'b00, 0, 0, 0, 0), "memadr_lw");
                for (int i = 0; i < mw; i++)
                    push(1'b0, rb(), o(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 0, 0, 0, 0),
                         "memread_wait");
                push(1'b1, rb(), o(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 0, 0, 0, 0), "memread");
                push(rb(), rb(), o(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, ADD, 2'b00, 1, 1, 0, 0), "memwb");
            end
            SW: begin
                push(rb(), rb(), o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 2'b01, 0, 0, 0, 0), "memadr_sw");
                for (int i = 0; i < mw; i++)
                    push(1'b0, rb(), o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 0, 0, 0, 0),
                         "memwrite_wait");
                push(1'b1, rb(), o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 0, 1, 0, 0), "memwrite");
            end
            RT: begin
                push(rb(), rb(), o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(f3, f7, 1'b1), 2'b00,
                                   0, 0, 0, 0), "execr");
                push(rb(), rb(), wb, "aluwb_r");
            end
            IT: begin
                push(rb(), rb(), o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(f3, f7, 1'b0), 2'b00,
                                   0, 0, 0, 0), "execi");
                push(rb(), rb(), wb, "aluwb_i");
            end
            BR: push(rb(), z, o((f3 == 3'd0) ? z : !z, 0, 0, 0, 2'b00, 2'b10, 2'b00, SUB, 2'b00,
                                0, 1, 0, 0), "branch");
            default: begin
                push(rb(), rb(), o(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD, 2'b11, 0, 0, 0, 0), "jal");
                push(rb(), rb(), wb, "aluwb_jal");
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            @(negedge clk);
            rst_n = 1'b1;
            op = c.opc; funct3 = c.f3; funct7_5 = c.f7;
            mem_ready = c.mr; zero = c.z;
            #1 check(c.tag, c.v);
        end
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = rb(); zero = rb(); op = 7'($urandom);
        #1 check(tag, 20'h0);
    endtask

    initial begin
        logic [6:0] opc;
        logic [2:0] f3;
        int kind;

        for (int i = 0; i < 3; i++) reset_cycle("reset");

        plan(RT, 3'd0, 1'b0, 1'b0, 0, 0);                          // add x3,x1,x2
        run(q.size());
        plan(LW, 3'd2, 1'b0, 1'b0, 0, 3);
        run(q.size());
        plan(BR, 3'd0, 1'b0, 1'b1, 0, 0);                          // beq, taken
        run(q.size());
        plan(BR, 3'd1, 1'b0, 1'b1, 0, 0);                          // bne, not taken
        run(q.size());
        plan(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
        run(q.size());
        plan(BR, 3'd2, 1'b0, 1'b0, 0, 0);                          // unsupported branch funct3
        run(q.size());
        plan(RT, 3'd0, 1'b1, 1'b0, 1, 0);                          // sub
        run(q.size());
        plan(RT, 3'd5, 1'b1, 1'b0, 0, 0);                          // sra
        run(q.size());
        plan(IT, 3'd0, 1'b1, 1'b0, 0, 0);                          // addi ignores bit 30
        run(q.size());
        plan(JL, 3'd0, 1'b0, 1'b0, 2, 0);
        run(q.size());
        plan(SW, 3'd2, 1'b0, 1'b0, 0, 4);                          // ready exactly at the limit
        run(q.size());

        // sw whose memory never answers: four waits, then the watchdog fires.
        cur_op = SW; cur_f3 = 3'd2; cur_f7 = 1'b0;
        fetch_cycles(0);
        decode_cycle(1'b0);
        push(rb(), rb(), o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, 2'b01, 0, 0, 0, 0), "memadr_sw");
        for (int i = 0; i < 4; i++)
            push(1'b0, rb(), o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 0, 0, 0, 0), "sw_wait");
        push(1'b0, rb(), o(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 2'b00, 0, 0, 0, 1), "sw_timeout");
        run(q.size());

        // Stalled fetch times out and retries in place.
        cur_op = RT; cur_f3 = 3'd0; cur_f7 = 1'b0;
        for (int i = 0; i < 4; i++)
            push(1'b0, rb(), o(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD, 2'b00, 0, 0, 0, 0), "fetch_wait");
        push(1'b0, rb(), o(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD, 2'b00, 0, 0, 0, 1), "fetch_timeout");
        run(q.size());
        plan(RT, 3'd7, 1'b0, 1'b0, 0, 0);
        run(q.size());

        // Reset in the write-back cycle suppresses the write and restarts at fetch.
        plan(RT, 3'd6, 1'b0, 1'b0, 0, 0);
        run(3);
        q.delete();
        reset_cycle("abort_wb");
        plan(IT, 3'd4, 1'b0, 1'b0, 0, 0);
        run(q.size());

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 6));
            f3 = 3'($urandom);
            case (kind)
                0: opc = LW;
                1: opc = SW;
                2: begin opc = RT; if (f3 == 3'd3) f3 = 3'd0; end
                3: begin opc = IT; if (f3 == 3'd3) f3 = 3'd1; end
                4: begin opc = BR; f3 = 3'($urandom % 2); end
                5: opc = JL;
                default: begin
                    case ($urandom % 4)
                        0: opc = 7'b0000000;
                        1: opc = 7'b1111111;
                        2: opc = 7'b0110111;
                        default: opc = 7'b1100111;
                    endcase
                end
            endcase
            plan(opc, f3, rb(), rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run(q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
